// File: rtl/pattern_decoder_ad974x.sv
// ---------------------------------------------------------------------------
// pattern_decoder_ad974x
//
// Receive side of the PWM/DAC pattern loopback. Digitized waveform samples
// (ADC capture of the DAC output) are thresholded into a bit line. Pattern
// frames are then recovered from that line: the bit values, the pattern length
// and a running frame count. The block is used for loopback self-test of the
// DDS path.
//
// Build option:
//   PATDEC_HYST_EN  defined   -> comparator with hysteresis (thr_hi / thr_lo)
//                   undefined -> single threshold thr_hi; thr_lo is ignored
//
// Ports:
//   clk, rst     system clock; asynchronous active-high reset
//   dec_en       decoder enable. Low forces IDLE on the next cycle.
//   adc_data     unsigned ADC sample, one per clk
//   thr_hi       high threshold
//   thr_lo       low threshold (hysteresis build only)
//   duty_num     clk cycles per pattern bit (0 behaves as 1)
//   gap_min      low-run length in cycles that terminates a frame
//   pulse_num    number of frames to capture; 0 means run continuously
//   pat_out      recovered pattern; bit0 is the first received bit
//   pat_len      index of the last '1' plus 1
//   frame_cnt    frames decoded since enable; wraps from 255 to 0
//   frame_valid  1-cycle pulse when pat_out/pat_len/err_ovf update
//   err_ovf      frame carried more than _PAT_WIDTH bits up to its last '1'
//   busy         high while the FSM is not IDLE
//   done         1-cycle pulse after pulse_num frames have been captured
//   state_dbg    current FSM state, for observation only
//
// Handshake: there is no backpressure. frame_valid and done are single-cycle
// strobes that qualify the output registers. A consumer must take the outputs
// in the strobe cycle. pat_out/pat_len/err_ovf then hold until the next strobe.
// ---------------------------------------------------------------------------
module pattern_decoder_ad974x #(
  parameter int _ADC_WIDTH = 8,
  parameter int _PAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_en,
  input  logic [_ADC_WIDTH-1:0] adc_data,
  input  logic [_ADC_WIDTH-1:0] thr_hi,
  input  logic [_ADC_WIDTH-1:0] thr_lo,
  input  logic [7:0]            duty_num,
  input  logic [15:0]           gap_min,
  input  logic [7:0]            pulse_num,
  output logic [_PAT_WIDTH-1:0] pat_out,
  output logic [7:0]            pat_len,
  output logic [7:0]            frame_cnt,
  output logic                  frame_valid,
  output logic                  err_ovf,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_EDGE = 3'd2,
    S_RECV      = 3'd3,
    S_FIN       = 3'd4
  } state_t;

  localparam int         IDX_W  = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;
  localparam logic [7:0] PAT_W8 = 8'(_PAT_WIDTH);

  state_t state, state_n;

  // -------------------------------------------------------------------------
  // Front end: sample register, then registered comparator (2 clk latency)
  // -------------------------------------------------------------------------
  logic [_ADC_WIDTH-1:0] adc_q;
  logic                  cmp_next;
  logic                  bit_q;
  logic                  bit_d;
  logic [15:0]           lowrun;

`ifdef PATDEC_HYST_EN
  // Between the thresholds the line keeps its previous level, so noise
  // inside the band cannot create edges.
  always_comb begin
    cmp_next = bit_q;
    if (adc_q >= thr_hi) begin
      cmp_next = 1'b1;
    end else if (adc_q < thr_lo) begin
      cmp_next = 1'b0;
    end
  end
`else
  logic unused_thr_lo;
  assign unused_thr_lo = ^thr_lo;
  assign cmp_next      = (adc_q >= thr_hi);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_q  <= '0;
      bit_q  <= 1'b0;
      bit_d  <= 1'b0;
      lowrun <= '0;
    end else begin
      adc_q <= adc_data;
      bit_q <= cmp_next;
      bit_d <= bit_q;
      if (bit_q) begin
        lowrun <= '0;
      end else if (lowrun != 16'hFFFF) begin
        lowrun <= lowrun + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Decoder working registers
  // -------------------------------------------------------------------------
  logic [7:0]            phase;
  logic [7:0]            bit_idx;
  logic [7:0]            last_one;
  logic [_PAT_WIDTH-1:0] shift_q;
  logic                  wait_drop;

  logic [7:0]            duty_eff;
  logic [7:0]            half;
  logic                  rise;
  logic                  gap_hit;
  logic [7:0]            frame_cnt_inc;
  logic                  last_frame;
  logic                  start_run;
  logic                  edge_start;
  logic                  recv_step;
  logic                  sample_now;
  logic                  capture;
  logic [IDX_W-1:0]      idx_lo;
  logic [_PAT_WIDTH-1:0] mask;

  assign duty_eff      = (duty_num == 8'd0) ? 8'd1 : duty_num;
  assign half          = duty_eff >> 1;
  assign rise          = bit_q & ~bit_d;
  assign gap_hit       = (lowrun >= gap_min);
  assign frame_cnt_inc = frame_cnt + 8'd1;
  assign last_frame    = (pulse_num != 8'd0) && (frame_cnt_inc == pulse_num);
  assign idx_lo        = bit_idx[IDX_W-1:0];

  // A completed run (FIN) blocks restart until dec_en has been seen low.
  assign start_run  = (state == S_IDLE) && dec_en && !wait_drop;
  assign edge_start = (state == S_WAIT_EDGE) && dec_en && rise;
  assign capture    = (state == S_RECV) && dec_en && gap_hit;
  assign recv_step  = (state == S_RECV) && dec_en && !gap_hit;

  // In the first RECV cycle phase is 0 and bit_d holds the line value at the
  // edge cycle. Sampling bit_d at phase == duty/2 therefore lands exactly
  // duty/2 cycles into each bit, and this also holds for duty 1 and 2.
  assign sample_now = recv_step && (phase == half);

  // Keep only bits [last_one:0]; an overflowed frame keeps the whole register.
  always_comb begin
    mask = '0;
    for (int i = 0; i < _PAT_WIDTH; i++) begin
      mask[i] = (8'(i) <= last_one);
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!dec_en) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!wait_drop) state_n = S_ARM;
        end
        S_ARM: begin
          // A start only counts after a full inter-frame gap, so a partial
          // frame already in flight at enable time is skipped.
          if (gap_hit) state_n = S_WAIT_EDGE;
        end
        S_WAIT_EDGE: begin
          if (rise) state_n = S_RECV;
        end
        S_RECV: begin
          if (gap_hit) state_n = last_frame ? S_FIN : S_WAIT_EDGE;
        end
        S_FIN: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= '0;
      bit_idx     <= '0;
      last_one    <= '0;
      shift_q     <= '0;
      wait_drop   <= 1'b0;
      pat_out     <= '0;
      pat_len     <= '0;
      frame_cnt   <= '0;
      frame_valid <= 1'b0;
      err_ovf     <= 1'b0;
      done        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      done        <= 1'b0;

      if (!dec_en) begin
        wait_drop <= 1'b0;
      end else if (state == S_FIN) begin
        wait_drop <= 1'b1;
      end

      if (start_run) begin
        frame_cnt <= '0;
      end

      if (edge_start) begin
        phase    <= '0;
        bit_idx  <= '0;
        last_one <= '0;
        shift_q  <= '0;
      end

      if (recv_step) begin
        phase <= (phase == duty_eff - 8'd1) ? 8'd0 : phase + 8'd1;
      end

      if (sample_now) begin
        if (bit_idx < PAT_W8) begin
          shift_q[idx_lo] <= bit_d;
        end
        if (bit_d) begin
          last_one <= bit_idx;
        end
        if (bit_idx != 8'hFF) begin
          bit_idx <= bit_idx + 8'd1;
        end
      end

      if (capture) begin
        pat_out     <= shift_q & mask;
        pat_len     <= last_one + 8'd1;
        err_ovf     <= (last_one >= PAT_W8);
        frame_cnt   <= frame_cnt_inc;
        frame_valid <= 1'b1;
      end

      if ((state == S_FIN) && dec_en) begin
        done <= 1'b1;
      end
    end
  end

endmodule
